// File: rtl/dsc_chunk_unpacker.sv
// Splits the DSC compressed byte stream into per-slice chunks and tags every
// byte with slice column/row, line-in-slice and chunk/slice/picture boundaries.
module dsc_chunk_unpacker #(
  parameter int SW_W  = 16,
  parameter int BPP_W = 10,
  parameter int SPL_W = 4,
  parameter int ROW_W = 8,
  parameter int CHK_W = 22
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [SW_W-1:0]  cfg_slice_width,
  input  logic [SW_W-1:0]  cfg_slice_height,
  input  logic [BPP_W-1:0] cfg_bpp,
  input  logic [SPL_W-1:0] cfg_slices_per_line,
  input  logic [ROW_W-1:0] cfg_slice_rows,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [7:0]       out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SPL_W-1:0] out_slice_col,
  output logic [ROW_W-1:0] out_slice_row,
  output logic [SW_W-1:0]  out_line,
  output logic             out_soc,
  output logic             out_eoc,
  output logic             out_eos,
  output logic             out_eop,
  output logic             busy,
  output logic             done,
  output logic             cfg_err
);

  localparam int PW = SW_W + BPP_W;

  typedef enum logic [1:0] {IDLE, CALC, RUN, DONE} state_t;

  state_t state, state_nxt;

  logic [SW_W-1:0]  sw_q, sh_q;
  logic [BPP_W-1:0] bpp_q;
  logic [SPL_W-1:0] spl_q;
  logic [ROW_W-1:0] rows_q;
  logic [CHK_W-1:0] chunk_q;

  logic [CHK_W-1:0] byte_cnt;
  logic [SPL_W-1:0] slice_col;
  logic [SW_W-1:0]  line;
  logic [ROW_W-1:0] slice_row;

  logic done_q, cfg_err_q;

  logic [PW-1:0]    prod;
  logic [PW:0]      rnd;
  logic [CHK_W-1:0] chunk_calc;
  logic             cfg_bad;
  logic             run, accept_start, xfer;
  logic             last_byte, last_col, last_line, last_row;
  logic             eos_i, eop_i;

  // Ceiling of width*bpp/128; one extra bit keeps the +127 from overflowing.
  assign prod       = PW'(sw_q) * PW'(bpp_q);
  assign rnd        = {1'b0, prod} + (PW+1)'(127);
  assign chunk_calc = CHK_W'(rnd[PW:7]);
  assign cfg_bad    = (chunk_calc == '0) || (spl_q == '0) || (sh_q == '0) || (rows_q == '0);

  assign run          = (state == RUN);
  assign accept_start = start && ((state == IDLE) || (state == DONE));
  assign xfer         = run && in_valid && out_ready;

  assign last_byte = (byte_cnt  == chunk_q - CHK_W'(1));
  assign last_col  = (slice_col == spl_q - SPL_W'(1));
  assign last_line = (line      == sh_q - SW_W'(1));
  assign last_row  = (slice_row == rows_q - ROW_W'(1));
  assign eos_i     = last_byte && last_line;
  assign eop_i     = eos_i && last_col && last_row;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (start) state_nxt = CALC;
      CALC:       state_nxt = cfg_bad ? DONE : RUN;
      RUN:        if (xfer && eop_i) state_nxt = DONE;
      default:    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sw_q      <= '0;
      sh_q      <= '0;
      bpp_q     <= '0;
      spl_q     <= '0;
      rows_q    <= '0;
      chunk_q   <= '0;
      byte_cnt  <= '0;
      slice_col <= '0;
      line      <= '0;
      slice_row <= '0;
      done_q    <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      done_q <= xfer && eop_i;
      if (accept_start) begin
        sw_q      <= cfg_slice_width;
        sh_q      <= cfg_slice_height;
        bpp_q     <= cfg_bpp;
        spl_q     <= cfg_slices_per_line;
        rows_q    <= cfg_slice_rows;
        chunk_q   <= '0;
        byte_cnt  <= '0;
        slice_col <= '0;
        line      <= '0;
        slice_row <= '0;
        cfg_err_q <= 1'b0;
      end
      if (state == CALC) begin
        chunk_q <= chunk_calc;
        if (cfg_bad) cfg_err_q <= 1'b1;
      end
      // Nested advance in encoder order: byte, then column, then line, then row.
      if (xfer) begin
        if (!last_byte) begin
          byte_cnt <= byte_cnt + CHK_W'(1);
        end else begin
          byte_cnt <= '0;
          if (!last_col) begin
            slice_col <= slice_col + SPL_W'(1);
          end else begin
            slice_col <= '0;
            if (!last_line) begin
              line <= line + SW_W'(1);
            end else begin
              line      <= '0;
              slice_row <= last_row ? '0 : slice_row + ROW_W'(1);
            end
          end
        end
      end
    end
  end

  assign in_ready      = run && out_ready;
  assign out_valid     = run && in_valid;
  assign out_data      = run ? in_data : '0;
  assign out_slice_col = slice_col;
  assign out_slice_row = slice_row;
  assign out_line      = line;
  assign out_soc       = run && (byte_cnt == '0);
  assign out_eoc       = run && last_byte;
  assign out_eos       = run && eos_i;
  assign out_eop       = run && eop_i;
  assign busy          = (state == CALC) || (state == RUN);
  assign done          = done_q;
  assign cfg_err       = cfg_err_q;

endmodule

// File: tb/tb_dsc_chunk_unpacker.sv
// Directed bench for dsc_chunk_unpacker: a picture-level model expands each
// configuration into the expected tagged byte sequence, checked every transfer.
module tb_dsc_chunk_unpacker;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] cfg_slice_width = '0;
  logic [15:0] cfg_slice_height = '0;
  logic [9:0]  cfg_bpp = '0;
  logic [3:0]  cfg_slices_per_line = '0;
  logic [7:0]  cfg_slice_rows = '0;
  logic [7:0]  in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [3:0]  out_slice_col;
  logic [7:0]  out_slice_row;
  logic [15:0] out_line;
  logic        out_soc, out_eoc, out_eos, out_eop;
  logic        busy, done, cfg_err;

  dsc_chunk_unpacker #(.SW_W(16), .BPP_W(10), .SPL_W(4), .ROW_W(8), .CHK_W(22)) dut (
    .clk(clk), .rst(rst), .start(start),
    .cfg_slice_width(cfg_slice_width), .cfg_slice_height(cfg_slice_height),
    .cfg_bpp(cfg_bpp), .cfg_slices_per_line(cfg_slices_per_line),
    .cfg_slice_rows(cfg_slice_rows),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_slice_col(out_slice_col), .out_slice_row(out_slice_row), .out_line(out_line),
    .out_soc(out_soc), .out_eoc(out_eoc), .out_eos(out_eos), .out_eop(out_eop),
    .busy(busy), .done(done), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  data;
    logic [3:0]  col;
    logic [7:0]  row;
    logic [15:0] line;
    logic        soc, eoc, eos, eop;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   out_idx = 0;
  int   model_cs = 0;
  int   seed = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] pat(input int k, input int s);
    return 8'((k * 37 + s * 11) & 255);
  endfunction

  // Picture model: ceiling chunk size, then rows > lines > columns > bytes.
  task automatic build_model(input int w, input int h, input int bpp, input int spl,
                             input int rows, input int s);
    exp_t e;
    int k = 0;
    model_cs = (w * bpp) / 128 + (((w * bpp) % 128) != 0 ? 1 : 0);
    for (int r = 0; r < rows; r++)
      for (int l = 0; l < h; l++)
        for (int c = 0; c < spl; c++)
          for (int b = 0; b < model_cs; b++) begin
            e.data = pat(k, s);
            e.col  = 4'(c);
            e.row  = 8'(r);
            e.line = 16'(l);
            e.soc  = (b == 0);
            e.eoc  = (b == model_cs - 1);
            e.eos  = e.eoc && (l == h - 1);
            e.eop  = e.eos && (c == spl - 1) && (r == rows - 1);
            exp_q.push_back(e);
            k++;
          end
  endtask

  // Checks outputs against the model on every cycle the DUT is out of reset.
  always @(negedge clk) begin
    exp_t act, e;
    if (!rst) begin
      if (!busy) begin
        chk("idle_out_valid", out_valid, 1'b0);
        chk("idle_in_ready", in_ready, 1'b0);
      end
      if (out_valid) begin
        chk("ready_passthru", in_ready, out_ready);
        chk("data_passthru", out_data, in_data);
      end
      if (out_valid && out_ready) begin
        act = {out_data, out_slice_col, out_slice_row, out_line,
               out_soc, out_eoc, out_eos, out_eop};
        if (exp_q.size() == 0) begin
          chk("extra_byte", 1'b1, 1'b0);
        end else begin
          e = exp_q.pop_front();
          chk($sformatf("byte%0d_tags", out_idx), act, e);
        end
        out_idx++;
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, in_ready, 1'b0);
    chk({tag, "_out_valid"}, out_valid, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
    chk({tag, "_cfg_err"}, cfg_err, 1'b0);
    chk({tag, "_flags"}, {out_soc, out_eoc, out_eos, out_eop}, 4'b0);
    chk({tag, "_tags"}, {out_slice_col, out_slice_row, out_line}, 28'b0);
  endtask

  task automatic set_cfg(input int w, input int h, input int bpp, input int spl, input int rows);
    cfg_slice_width     = 16'(w);
    cfg_slice_height    = 16'(h);
    cfg_bpp             = 10'(bpp);
    cfg_slices_per_line = 4'(spl);
    cfg_slice_rows      = 8'(rows);
  endtask

  // Runs one picture from start; abort_after>0 resets the DUT after that many bytes.
  task automatic run_pic(input int w, input int h, input int bpp, input int spl,
                         input int rows, input bit stall, input int abort_after);
    int n, sent, cyc;
    bit fire;
    seed++;
    exp_q.delete();
    out_idx = 0;
    build_model(w, h, bpp, spl, rows, seed);
    n = exp_q.size();
    set_cfg(w, h, bpp, spl, rows);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    sent = 0;
    cyc = 0;
    while (sent < n && cyc < 20 * n + 50) begin
      in_valid  = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
      out_ready = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
      in_data   = pat(sent, seed);
      @(negedge clk);
      if (cyc == 0) chk("cfg_err_cleared", cfg_err, 1'b0);
      fire = in_valid && in_ready;
      @(posedge clk); #1;
      cyc++;
      if (fire) sent++;
      if (abort_after > 0 && sent == abort_after) break;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    if (abort_after > 0) begin
      rst = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      check_reset_outputs("mid_reset");
      exp_q.delete();
      @(posedge clk); #1;
      rst = 1'b0;
    end else begin
      chk("bytes_sent", sent, n);
      if (!stall) chk("latency_cycles", cyc, n + 1);
      @(negedge clk);
      chk("done_pulse", done, 1'b1);
      chk("busy_after", busy, 1'b0);
      chk("model_drained", exp_q.size(), 0);
      @(negedge clk);
      chk("done_one_cycle", done, 1'b0);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // Hand-computed pins on the model for the basic case.
    build_model(8, 2, 128, 2, 1, 0);
    chk("pin1_count", exp_q.size(), 32);
    chk("pin1_eoc7", exp_q[7].eoc, 1'b1);
    chk("pin1_soc8_col", {exp_q[8].soc, exp_q[8].col}, 5'b1_0001);
    chk("pin1_line16", exp_q[16].line, 16'd1);
    chk("pin1_eos15", exp_q[15].eos, 1'b0);
    chk("pin1_eos23", exp_q[23].eos, 1'b1);
    chk("pin1_eop31", exp_q[31].eop, 1'b1);
    exp_q.delete();
    build_model(9, 1, 120, 1, 1, 0);
    chk("pin2_chunk", model_cs, 9);
    chk("pin2_eoc8", exp_q[8].eoc, 1'b1);
    exp_q.delete();
    build_model(1, 3, 128, 1, 2, 0);
    chk("pin3_count", exp_q.size(), 6);
    chk("pin3_soc_eoc4", {exp_q[4].soc, exp_q[4].eoc}, 2'b11);
    chk("pin3_eos2", exp_q[2].eos, 1'b1);
    chk("pin3_eop2", exp_q[2].eop, 1'b0);
    exp_q.delete();

    run_pic(8, 2, 128, 2, 1, 1'b0, 0);
    run_pic(9, 2, 120, 2, 1, 1'b0, 0);
    run_pic(8, 2, 128, 2, 1, 1'b1, 0);

    // Zero bpp gives a zero chunk size: error two cycles after start, nothing accepted.
    set_cfg(8, 2, 0, 2, 1);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("bad_cfg_err_early", cfg_err, 1'b0);
    chk("bad_busy_calc", busy, 1'b1);
    chk("bad_in_ready_calc", in_ready, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("bad_cfg_err", cfg_err, 1'b1);
    chk("bad_busy", busy, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("bad_in_ready", in_ready, 1'b0);
      chk("bad_no_done", done, 1'b0);
      chk("bad_err_sticky", cfg_err, 1'b1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    @(posedge clk); #1;

    run_pic(5, 2, 200, 3, 2, 1'b1, 0);
    run_pic(8, 2, 128, 2, 1, 1'b0, 10);
    run_pic(8, 2, 128, 2, 1, 1'b0, 0);
    run_pic(1, 3, 128, 1, 2, 1'b0, 0);
    run_pic(1, 3, 128, 1, 2, 1'b1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dsc_chunk_unpacker.md
Name: dsc_chunk_unpacker

Overview:
- Decoder-side front end for the DSC path.
- Consumes the compressed byte stream that the encoder produces in cmpr_buf order and splits it into per-slice chunks.
- Tags every byte with slice column, slice row and line-in-slice, plus chunk, slice and picture boundary flags, so downstream slice decoders can each take their own chunks.
- Runtime configuration mirrors the DSC config fields (slice_width, slice_height, bits_per_pixel).

Parameters:
- SW_W, 16, width of slice_width and slice_height fields
- BPP_W, 10, width of bits_per_pixel field (units of 1/16 bpp)
- SPL_W, 4, width of slices-per-line count
- ROW_W, 8, width of slice-row count
- CHK_W, 22, width of chunk byte counter (holds ceil(2^SW_W * 2^BPP_W / 128))

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle pulse; latches cfg_*; ignored unless in IDLE or DONE
- cfg_slice_width  in  SW_W  pixels per slice line
- cfg_slice_height  in  SW_W  lines per slice
- cfg_bpp  in  BPP_W  bits per pixel x16
- cfg_slices_per_line  in  SPL_W  slices across picture
- cfg_slice_rows  in  ROW_W  slices down picture
- in_data  in  8  compressed byte
- in_valid  in  1  byte valid
- in_ready  out  1  byte accepted when in_valid&in_ready
- out_data  out  8  byte
- out_valid  out  1  output valid
- out_ready  in  1  downstream ready
- out_slice_col  out  SPL_W  slice column of byte
- out_slice_row  out  ROW_W  slice row of byte
- out_line  out  SW_W  line within slice
- out_soc  out  1  first byte of chunk
- out_eoc  out  1  last byte of chunk
- out_eos  out  1  last byte of last chunk of a slice
- out_eop  out  1  last byte of picture
- busy  out  1  state != IDLE and != DONE
- done  out  1  one-cycle pulse after last byte accepted
- cfg_err  out  1  sticky until next start; bad config

Behaviour:
- Single clock; reset is synchronous and active-high; all state changes occur on the rising edge of clk.
- Reset values: state=IDLE, all counters 0, in_ready=0, out_valid=0, tags/flags 0, busy=0, done=0, cfg_err=0.
- FSM states: IDLE, CALC, RUN, DONE.
  - IDLE/DONE --start--> CALC: latch cfg_*, clear counters and cfg_err.
  - CALC (1 cycle): chunk_size = ceil(slice_width*bpp/128), product 26 bits unsigned, computed as (prod+127)>>7.
    - If chunk_size==0, slices_per_line==0, slice_height==0 or slice_rows==0: set cfg_err, go DONE, no done pulse.
    - Otherwise go RUN.
  - RUN: pass-through. out_valid=in_valid, in_ready=out_ready, out_data=in_data, all combinational; zero latency.
    - Tags and flags are combinational from the registered counters.
  - Outside RUN: in_ready=0, out_valid=0.
- Counters advance only on a transfer (out_valid&out_ready), nested innermost first: byte_cnt (0..chunk_size-1), slice_col, line, slice_row.
  - Byte order matches the encoder: for each slice row, for each line, for each slice column, chunk_size bytes.
- Flag definitions:
  - soc = (byte_cnt==0).
  - eoc = (byte_cnt==chunk_size-1).
  - eos = eoc & (line==slice_height-1).
  - eop = eos & (slice_col==spl-1) & (slice_row==rows-1).
  - chunk_size==1 gives soc=eoc=1 on the same byte.
- Transfer with eop: go DONE; done pulses high for the next cycle only.
- start during RUN or CALC is ignored.
- start arriving in the same cycle as the final transfer: the final transfer completes; start is ignored.
- rst mid-picture: immediate return to reset values; the partial picture is discarded.
- Total bytes per picture = chunk_size*spl*slice_height*rows.

Test Plan:
- Basic pass-through: slice_width=8, bpp=128, spl=2, height=2, rows=1, continuous valid/ready.
  - Required: 32 bytes out, zero latency; soc at bytes 0,8,16,24; eoc at 7,15,23,31.
  - Required: slice_col sequence 0,1,0,1 per chunk; line 0,0,1,1.
  - Required: eos at bytes 23 and 31; eop at 31; done one cycle after byte 31.
- Fractional bpp: width=9, bpp=120 -> chunk_size=9 (1080/128=8.4375 rounded up). eoc on every 9th byte.
- Backpressure: random out_ready and in_valid.
  - Required: in_ready==out_ready in RUN; data order and tags identical to the no-stall run; no counter movement on stalled cycles.
- Bad config: bpp=0 -> cfg_err=1 two cycles after start; no bytes accepted; in_ready stays 0.
  - A subsequent valid start clears cfg_err.
- Reset mid-run after byte 10 of case 1:
  - Required: next cycle all outputs at reset values.
  - Required: a new start restarts at slice_col=0, line=0, soc=1.
- chunk_size=1 (width=1, bpp=128), spl=1, height=3, rows=2: 6 bytes; every byte has soc=eoc=1; eos on bytes 2 and 5; eop on byte 5.
